// File: rtl/instr_fetch_unit.sv
// Fetch stage: one-entry instruction buffer in front of a variable-latency imem (req/ack).
// Defining INSTR_FETCH_PREFETCH_EN adds a second entry filled by next-line prefetch.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              fetch_err,
    output logic [1:0]        state_dbg
);

    // Handshake: imem_req/imem_addr are registered and held stable until the cycle
    // imem_ack=1; that cycle completes the transfer and imem_req drops at the next edge.
    // imem_ack is ignored while imem_req=0, including a late ack after a timeout.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PWAIT, S_ERR} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        count;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              hit_buf;
    logic              hit_nbuf;
    logic              hit;

`ifdef INSTR_FETCH_PREFETCH_EN
    logic              nbuf_valid;
    logic [ADDR_W-1:0] nbuf_addr;
    logic [DATA_W-1:0] nbuf_data;
    logic              pf_pending;
`endif

    always_comb begin
        hit_buf  = buf_valid && (pc == buf_addr) && (state != S_ERR);
`ifdef INSTR_FETCH_PREFETCH_EN
        hit_nbuf = nbuf_valid && (pc == nbuf_addr) && (state != S_ERR);
`else
        hit_nbuf = 1'b0;
`endif
        hit         = hit_buf || hit_nbuf;
        instr_valid = hit;
        stall       = ~hit;
        instr       = NOP_INSTR;
        if (hit_buf) begin
            instr = buf_data;
`ifdef INSTR_FETCH_PREFETCH_EN
        end else if (hit_nbuf) begin
            instr = nbuf_data;
`endif
        end
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            count      <= 8'd0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= NOP_INSTR;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            fetch_err  <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
            nbuf_valid <= 1'b0;
            nbuf_addr  <= '0;
            nbuf_data  <= NOP_INSTR;
            pf_pending <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (!hit) begin
                        if (pc[1:0] != 2'b00) begin
                            state     <= S_ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            count     <= 8'd0;
                            state     <= S_WAIT;
                        end
`ifdef INSTR_FETCH_PREFETCH_EN
                    end else if (!hit_buf) begin
                        // Demand hit on the prefetched line promotes it and chains the next prefetch.
                        buf_valid  <= 1'b1;
                        buf_addr   <= nbuf_addr;
                        buf_data   <= nbuf_data;
                        nbuf_valid <= 1'b0;
                        pf_pending <= 1'b1;
                    end else if (pf_pending) begin
                        imem_req  <= 1'b1;
                        imem_addr <= buf_addr + ADDR_W'(4);
                        count     <= 8'd0;
                        state     <= S_PWAIT;
`endif
                    end
                end
                S_WAIT, S_PWAIT: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= S_IDLE;
                        if (state == S_WAIT) begin
                            buf_valid <= 1'b1;
                            buf_addr  <= imem_addr;
                            buf_data  <= imem_rdata;
                        end
`ifdef INSTR_FETCH_PREFETCH_EN
                        if (state == S_WAIT) begin
                            pf_pending <= 1'b1;
                        end else begin
                            nbuf_valid <= 1'b1;
                            nbuf_addr  <= imem_addr;
                            nbuf_data  <= imem_rdata;
                            pf_pending <= 1'b0;
                        end
`endif
                    end else if (count == TO_LAST) begin
                        imem_req  <= 1'b0;
                        state     <= S_ERR;
                        fetch_err <= 1'b1;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: transaction-level reference model checked every
// negedge, an in-order queue of expected request addresses, and literal spot checks.
module tb_instr_fetch_unit;

    localparam int          TO  = 16;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        fetch_err;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .fetch_err(fetch_err), .state_dbg(state_dbg)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    // Reference model: what the buffer holds, whether a request is outstanding, sticky error.
    logic        m_valid, m_err, m_req;
    logic [31:0] m_addr, m_data, m_req_addr;
    int          m_age;
    logic        chk_en = 1'b0;
    logic        prev_req = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t, state_dbg=%0d)",
                     name, act, req, $time, state_dbg);
        end
    endtask

    function automatic logic m_hit();
        return m_valid && (pc == m_addr) && !m_err;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_err = 1'b0; m_req = 1'b0;
        m_addr = 32'h0; m_data = NOP; m_req_addr = 32'h0; m_age = 0;
    endtask

    // Advances the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        if (!reset) begin
            model_reset();
        end else if (m_req) begin
            if (imem_ack) begin
                m_valid = 1'b1; m_addr = m_req_addr; m_data = imem_rdata; m_req = 1'b0;
            end else if (m_age == TO - 1) begin
                m_req = 1'b0; m_err = 1'b1;
            end else begin
                m_age++;
            end
        end else if (!m_err && !m_hit()) begin
            if (pc[1:0] != 2'b00) begin
                m_err = 1'b1;
            end else begin
                m_req = 1'b1; m_req_addr = pc; m_age = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("instr_valid", {31'h0, instr_valid}, {31'h0, m_hit()});
            cmp("instr", instr, m_hit() ? m_data : NOP);
            cmp("stall", {31'h0, stall}, {31'h0, !m_hit()});
            cmp("imem_req", {31'h0, imem_req}, {31'h0, m_req});
            if (m_req) cmp("imem_addr", imem_addr, m_req_addr);
            cmp("fetch_err", {31'h0, fetch_err}, {31'h0, m_err});
            if (imem_req && !prev_req) begin
                if (exp_q.size() == 0) cmp("req_unexpected", imem_addr, 32'hFFFF_FFFF);
                else cmp("req_order", imem_addr, exp_q.pop_front());
            end
            prev_req = imem_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 40) begin
            tick();
            n++;
        end
        if (!imem_req) cmp("req_wait_bound", {31'h0, imem_req}, 32'h1);
    endtask

    task automatic serve(input int dly, input logic [31:0] data);
        wait_req();
        repeat (dly) tick();
        imem_ack = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic hard_reset();
        reset = 1'b0;
        model_reset();
    endtask

    logic [31:0] t_pc[4]  = '{32'h20, 32'h24, 32'h100, 32'h24};
    int          t_dly[4] = '{0, 2, 3, 1};

    initial begin
        int n;
        model_reset();
        chk_en = 1'b1;
        #1;
        cmp("rst_instr", instr, NOP);
        cmp("rst_valid", {31'h0, instr_valid}, 32'h0);
        cmp("rst_stall", {31'h0, stall}, 32'h1);
        tick(); tick();
        reset = 1'b1;

        // Minimum-latency miss at pc=0.
        exp_q.push_back(32'h0);
        serve(0, 32'h03A0_3002);
        cmp("t1_instr", instr, 32'h03A0_3002);
        cmp("t1_valid", {31'h0, instr_valid}, 32'h1);
        cmp("t1_stall", {31'h0, stall}, 32'h0);

        // Hold pc; a stray ack with no request must not disturb the buffer.
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        repeat (3) tick();
        imem_ack = 1'b0;
        cmp("t2_noreq", {31'h0, imem_req}, 32'h0);
        cmp("t2_instr", instr, 32'h03A0_3002);

        // Slow memory.
        pc = 32'h4;
        exp_q.push_back(32'h4);
        serve(5, 32'h0283_3001);
        cmp("t3_instr", instr, 32'h0283_3001);

        // Timeout: request lasts exactly TIMEOUT cycles, then sticky error.
        pc = 32'h8;
        exp_q.push_back(32'h8);
        wait_req();
        n = 0;
        while (imem_req && n < 40) begin
            tick();
            n++;
        end
        cmp("t4_req_len", n, TO);
        cmp("t4_err", {31'h0, fetch_err}, 32'h1);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        imem_ack = 1'b0;
        cmp("t4_late_instr", instr, NOP);
        cmp("t4_late_valid", {31'h0, instr_valid}, 32'h0);

        // Misaligned pc after a reset pulse.
        hard_reset();
        tick();
        pc = 32'h6;
        reset = 1'b1;
        tick();
        cmp("t5_err", {31'h0, fetch_err}, 32'h1);
        cmp("t5_noreq", {31'h0, imem_req}, 32'h0);
        hard_reset();
        #1;
        cmp("t5_err_clr", {31'h0, fetch_err}, 32'h0);
        cmp("t5_valid", {31'h0, instr_valid}, 32'h0);

        // pc moves during WAIT: stale fill lands, then a fresh miss for the new pc.
        pc = 32'h10;
        tick();
        reset = 1'b1;
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h14);
        wait_req();
        tick(); tick();
        pc = 32'h14;
        serve(0, 32'hAAAA_0010);
        cmp("t6_stale_valid", {31'h0, instr_valid}, 32'h0);
        cmp("t6_stale_stall", {31'h0, stall}, 32'h1);
        serve(1, 32'h5555_0014);
        cmp("t6_instr", instr, 32'h5555_0014);

        // Back-to-back misses with assorted latencies.
        for (int i = 0; i < 4; i++) begin
            pc = t_pc[i];
            exp_q.push_back(t_pc[i]);
            serve(t_dly[i], {16'hC0DE, t_pc[i][15:0]});
            cmp("t7_instr", instr, {16'hC0DE, t_pc[i][15:0]});
        end

        // Reset asserted mid-WAIT drops the request at once.
        pc = 32'h40;
        exp_q.push_back(32'h40);
        wait_req();
        tick();
        #2;
        hard_reset();
        #1;
        cmp("t8_req_drop", {31'h0, imem_req}, 32'h0);
        cmp("t8_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        reset = 1'b1;
        exp_q.push_back(32'h40);
        serve(0, 32'h4040_4040);
        cmp("t8_refetch", instr, 32'h4040_4040);
        tick();

        cmp("exp_q_drained", exp_q.size(), 32'h0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
